// File: rtl/prbs_checker.sv
// ---------------------------------------------------------------------------
// prbs_checker
//   Serial PRBS checker for the 5-bit Fibonacci LFSR generator. A local
//   shadow LFSR fills from the received stream (SEARCH), confirms
//   LOCK_COUNT consecutive correct predictions (VERIFY), and then counts
//   mispredicted bits (LOCKED). After UNLOCK_ERRS consecutive mispredictions
//   the checker re-searches.
//
//   Build option: define PRBS_CHECKER_FLYWHEEL_EN to make the shadow
//   free-run on its own prediction while LOCKED. A single channel error
//   then costs exactly one count.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   bit_valid     qualifies bit_in; invalid cycles change no state
//   bit_in        received serial bit
//   taps          feedback tap mask (same encoding as the generator)
//   clear_cnt     synchronous clear of err_count (wins over an increment)
//   locked        high while in LOCKED
//   error_pulse   one-cycle strobe per mispredicted bit while LOCKED
//   err_count     saturating misprediction count
//   shadow_state  shadow register, for debug
// ---------------------------------------------------------------------------
module prbs_checker #(
    parameter int WIDTH       = 5,
    parameter int LOCK_COUNT  = 8,
    parameter int UNLOCK_ERRS = 4,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    input  logic [WIDTH-1:0]     taps,
    input  logic                 clear_cnt,
    output logic                 locked,
    output logic                 error_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [WIDTH-1:0]     shadow_state
);

    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     shadow_q, shadow_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0]     match_q, match_d;
    logic [CNT_W-1:0]     bad_q, bad_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 pulse_q, pulse_d;

    logic                 pred;
    logic                 mismatch;
    logic                 err_inc;
    logic [WIDTH-1:0]     shifted_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SEARCH;
            shadow_q <= '0;
            fill_q   <= '0;
            match_q  <= '0;
            bad_q    <= '0;
            err_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            fill_q   <= fill_d;
            match_q  <= match_d;
            bad_q    <= bad_d;
            err_q    <= err_d;
            pulse_q  <= pulse_d;
        end
    end

    always_comb begin
        pred       = ^(shadow_q & taps);
        mismatch   = (bit_in != pred);
        shifted_in = {shadow_q[WIDTH-2:0], bit_in};

        state_d  = state_q;
        shadow_d = shadow_q;
        fill_d   = fill_q;
        match_d  = match_q;
        bad_d    = bad_q;
        pulse_d  = 1'b0;
        err_inc  = 1'b0;

        if (bit_valid) begin
            case (state_q)
                SEARCH: begin
                    shadow_d = shifted_in;
                    fill_d   = fill_q + FILL_W'(1);
                    if (fill_q == FILL_W'(WIDTH - 1)) begin
                        state_d = VERIFY;
                        match_d = '0;
                    end
                end

                VERIFY: begin
                    shadow_d = shifted_in;
                    // An all-zero shadow predicts 0 forever; refusing to
                    // count it keeps a dead line from ever locking.
                    if (!mismatch && (shadow_q != '0)) begin
                        match_d = match_q + CNT_W'(1);
                        if (match_q == CNT_W'(LOCK_COUNT - 1)) begin
                            state_d = LOCKED;
                            bad_d   = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end

                LOCKED: begin
`ifdef PRBS_CHECKER_FLYWHEEL_EN
                    // Free-run on the prediction so a channel error never
                    // enters the shadow.
                    shadow_d = {shadow_q[WIDTH-2:0], pred};
`else
                    shadow_d = shifted_in;
`endif
                    if (mismatch) begin
                        pulse_d = 1'b1;
                        err_inc = 1'b1;
                        bad_d   = bad_q + CNT_W'(1);
                    end else begin
                        bad_d   = '0;
                    end

                    if (mismatch && (bad_q == CNT_W'(UNLOCK_ERRS - 1))) begin
                        state_d = SEARCH;
                    end
`ifndef PRBS_CHECKER_FLYWHEEL_EN
                    if (shifted_in == '0) begin
                        state_d = SEARCH;
                    end
`endif
                    if (state_d == SEARCH) begin
                        fill_d  = '0;
                        match_d = '0;
                        bad_d   = '0;
                    end
                end

                default: begin
                    state_d = SEARCH;
                    fill_d  = '0;
                    match_d = '0;
                    bad_d   = '0;
                end
            endcase
        end

        // Clear has priority over a same-cycle increment.
        err_d = err_q;
        if (clear_cnt) begin
            err_d = '0;
        end else if (err_inc && (err_q != '1)) begin
            err_d = err_q + ERR_CNT_W'(1);
        end
    end

    assign locked       = (state_q == LOCKED);
    assign error_pulse  = pulse_q;
    assign err_count    = err_q;
    assign shadow_state = shadow_q;

endmodule

// File: tb/tb_prbs_checker.sv
// ---------------------------------------------------------------------------
// tb_prbs_checker
//   Directed bench for prbs_checker (WIDTH=5, LOCK_COUNT=8, UNLOCK_ERRS=4,
//   ERR_CNT_W=4). The reference stream is one period of x^5+x^2+1
//   (taps 5'b10010), written out by hand. Inputs change 1 time unit after
//   the rising edge; outputs are sampled at that same point, so each sample
//   shows the state the previous edge produced.
// ---------------------------------------------------------------------------
module tb_prbs_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_valid;
    logic       bit_in;
    logic [4:0] taps;
    logic       clear_cnt;
    logic       locked;
    logic       error_pulse;
    logic [3:0] err_count;
    logic [4:0] shadow_state;

    int vectors     = 0;
    int miscompares = 0;

    // b[n] = b[n-2] ^ b[n-5], starting 1,0,1,0,1; index 0 is the leftmost char.
    logic [0:30] seq;

`ifdef PRBS_CHECKER_FLYWHEEL_EN
    // One flipped bit costs one count when the shadow free-runs.
    localparam int SINGLE_ERRS = 1;
    // Flywheel keeps tracking the true stream, so constant 1 only
    // mispredicts where the true bit is 0; b27..b30 are the first four
    // zeros in a row -> drop on the 18th one, 9 mispredictions in total.
    localparam int ONES_N   = 18;
    localparam int DROP_ERR = 9;
`else
    // The flipped bit mispredicts once itself and once more under each of
    // the two taps (predicting b17 and b20): three counts.
    localparam int SINGLE_ERRS = 3;
    // Shadow 11000 at lock: the first five ones are predicted correctly,
    // then 11111 predicts 0 -> four misses on ones 6..9.
    localparam int ONES_N   = 9;
    localparam int DROP_ERR = 4;
`endif

    prbs_checker #(
        .WIDTH(5), .LOCK_COUNT(8), .UNLOCK_ERRS(4), .ERR_CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
        .taps(taps), .clear_cnt(clear_cnt), .locked(locked),
        .error_pulse(error_pulse), .err_count(err_count),
        .shadow_state(shadow_state)
    );

    always #5 clk = ~clk;

    task automatic send(input logic v, input logic b);
        bit_valid = v;
        bit_in    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        clear_cnt = 1'b0;
        taps      = 5'b10010;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic lock_from_start();
        for (int i = 0; i < 13; i++) send(1'b1, seq[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; clear_cnt = 1'b0; taps = 5'b10010;
        @(posedge clk); #1;
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked got %b want 0", locked); end
        vectors++; if (error_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_pulse got %b want 0", error_pulse); end
        vectors++; if (err_count !== 4'd0) begin miscompares++; $display("FAIL reset_err got %0d want 0", err_count); end
        vectors++; if (shadow_state !== 5'd0) begin miscompares++; $display("FAIL reset_shadow got %b want 00000", shadow_state); end
        rst = 1'b0;
    endtask

    task automatic test_lock();
        do_reset();
        for (int i = 0; i < 13; i++) begin
            send(1'b1, seq[i]);
            vectors++; if (locked !== (i == 12)) begin miscompares++; $display("FAIL lock_bit%0d got %b want %b", i+1, locked, (i == 12)); end
            vectors++; if (error_pulse !== 1'b0) begin miscompares++; $display("FAIL lock_pulse bit%0d got %b want 0", i+1, error_pulse); end
            if (i == 4) begin
                vectors++; if (shadow_state !== 5'b10101) begin miscompares++; $display("FAIL lock_fill got %b want 10101", shadow_state); end
            end
        end
        vectors++; if (err_count !== 4'd0) begin miscompares++; $display("FAIL lock_err got %0d want 0", err_count); end
    endtask

    task automatic test_gaps();
        logic [4:0] exp_sh;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            send(1'b1, seq[i]);
            for (int k = 0; k < 5; k++) exp_sh[k] = (i - k >= 0) ? seq[i-k] : 1'b0;
            // Invalid cycle with the opposite bit: must be ignored.
            send(1'b0, ~seq[(i+1) % 31]);
            vectors++; if (shadow_state !== exp_sh) begin miscompares++; $display("FAIL gap_shadow bit%0d got %b want %b", i+1, shadow_state, exp_sh); end
            vectors++; if (locked !== (i == 12)) begin miscompares++; $display("FAIL gap_lock bit%0d got %b want %b", i+1, locked, (i == 12)); end
            vectors++; if (error_pulse !== 1'b0) begin miscompares++; $display("FAIL gap_pulse bit%0d got %b want 0", i+1, error_pulse); end
        end
    endtask

    task automatic test_single_error();
        int pulses;
        do_reset();
        lock_from_start();
        pulses = 0;
        for (int i = 13; i < 28; i++) begin
            send(1'b1, seq[i] ^ (i == 15));
            if (error_pulse === 1'b1) pulses++;
        end
        send(1'b0, 1'b0);
        if (error_pulse === 1'b1) pulses++;
        vectors++; if (err_count !== 4'(SINGLE_ERRS)) begin miscompares++; $display("FAIL single_err got %0d want %0d", err_count, SINGLE_ERRS); end
        vectors++; if (pulses !== SINGLE_ERRS) begin miscompares++; $display("FAIL single_pulses got %0d want %0d", pulses, SINGLE_ERRS); end
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL single_locked got %b want 1", locked); end
    endtask

    task automatic test_loss_of_lock();
        int r;
        do_reset();
        lock_from_start();
        for (int k = 1; k <= ONES_N; k++) begin
            send(1'b1, 1'b1);
            if (k == ONES_N - 1) begin
                vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL loss_prelock got %b want 1", locked); end
                vectors++; if (err_count !== 4'(DROP_ERR - 1)) begin miscompares++; $display("FAIL loss_preerr got %0d want %0d", err_count, DROP_ERR - 1); end
            end
        end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL loss_drop got %b want 0", locked); end
        vectors++; if (err_count !== 4'(DROP_ERR)) begin miscompares++; $display("FAIL loss_err got %0d want %0d", err_count, DROP_ERR); end
        // Generator kept advancing while the line was stuck.
        r = 13 + ONES_N;
        for (int j = 0; j < 13; j++) begin
            send(1'b1, seq[(r + j) % 31]);
            vectors++; if (locked !== (j == 12)) begin miscompares++; $display("FAIL relock_bit%0d got %b want %b", j+1, locked, (j == 12)); end
        end
        vectors++; if (err_count !== 4'(DROP_ERR)) begin miscompares++; $display("FAIL relock_err got %0d want %0d", err_count, DROP_ERR); end
        clear_cnt = 1'b1;
        send(1'b0, 1'b0);
        clear_cnt = 1'b0;
        vectors++; if (err_count !== 4'd0) begin miscompares++; $display("FAIL idle_clear got %0d want 0", err_count); end
    endtask

    task automatic test_all_zero();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            send(1'b1, 1'b0);
            vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL zero_lock bit%0d got %b want 0", i+1, locked); end
        end
        vectors++; if (err_count !== 4'd0) begin miscompares++; $display("FAIL zero_err got %0d want 0", err_count); end
    endtask

    task automatic test_saturation_clear();
        int nmis;
        do_reset();
        lock_from_start();
        // Empty tap mask predicts 0: every 1 is a miss, every 4th bit is a
        // 0 so the bad run never reaches four.
        taps = 5'b00000;
        nmis = 0;
        for (int i = 0; i < 26; i++) begin
            send(1'b1, (i % 4) != 3);
            if ((i % 4) != 3) nmis++;
            vectors++; if (err_count !== 4'((nmis > 15) ? 15 : nmis)) begin miscompares++; $display("FAIL sat_step%0d got %0d want %0d", i, err_count, (nmis > 15) ? 15 : nmis); end
        end
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL sat_locked got %b want 1", locked); end
        clear_cnt = 1'b1;
        send(1'b1, 1'b1);
        clear_cnt = 1'b0;
        vectors++; if (err_count !== 4'd0) begin miscompares++; $display("FAIL clear_vs_inc got %0d want 0", err_count); end
        vectors++; if (error_pulse !== 1'b1) begin miscompares++; $display("FAIL clear_pulse got %b want 1", error_pulse); end
        send(1'b1, 1'b0);
        vectors++; if (error_pulse !== 1'b0) begin miscompares++; $display("FAIL match_pulse got %b want 0", error_pulse); end
        send(1'b1, 1'b1);
        vectors++; if (err_count !== 4'd1) begin miscompares++; $display("FAIL post_clear_inc got %0d want 1", err_count); end
        rst = 1'b1;
        send(1'b1, 1'b1);
        rst = 1'b0;
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL rst_locked got %b want 0", locked); end
        vectors++; if (error_pulse !== 1'b0) begin miscompares++; $display("FAIL rst_pulse got %b want 0", error_pulse); end
        vectors++; if (err_count !== 4'd0) begin miscompares++; $display("FAIL rst_err got %0d want 0", err_count); end
        vectors++; if (shadow_state !== 5'd0) begin miscompares++; $display("FAIL rst_shadow got %b want 00000", shadow_state); end
    endtask

    initial begin
        seq = 31'b1010111011000111110011010010000;
        test_reset();
        test_lock();
        test_gaps();
        test_single_error();
        test_loss_of_lock();
        test_all_zero();
        test_saturation_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
